// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared constants and state encoding for the MEM-stage access unit
// Contents:
//   DATA_BASE_DEFAULT / DATA_WORDS_DEFAULT : default data segment placement and size
//   EXC_* : exception codes reported on exc_code
//   state_e : access unit FSM states
package mem_pkg;

  localparam logic [31:0] DATA_BASE_DEFAULT  = 32'h1001_0000;
  localparam int          DATA_WORDS_DEFAULT = 1024;

  localparam logic [1:0] EXC_NONE     = 2'd0;
  localparam logic [1:0] EXC_MISALIGN = 2'd1;
  localparam logic [1:0] EXC_RANGE    = 2'd2;
  localparam logic [1:0] EXC_BOTH     = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } state_e;

endpackage

// File: rtl/mem_addr_check.sv
// rtl/mem_addr_check.sv - combinational legality check for a data memory access
// Ports:
//   addr     in  32  byte address of the access
//   load     in  1   access is a load
//   store    in  1   access is a store
//   legal    out 1   access may proceed (always 1 for non-memory ops)
//   exc_code out 2   EXC_NONE / EXC_MISALIGN / EXC_RANGE / EXC_BOTH
module mem_addr_check
  import mem_pkg::*;
#(
  parameter logic [31:0] DATA_BASE  = DATA_BASE_DEFAULT,
  parameter int          DATA_WORDS = DATA_WORDS_DEFAULT
) (
  input  logic [31:0] addr,
  input  logic        load,
  input  logic        store,
  output logic        legal,
  output logic [1:0]  exc_code
);

  // One past the last byte of the segment, kept in 33 bits so a segment
  // ending at the top of the address space does not wrap to zero.
  localparam logic [32:0] UPPER = {1'b0, DATA_BASE} + (33'(DATA_WORDS) << 2);

  always_comb begin
    exc_code = EXC_NONE;
    if (load && store) begin
      exc_code = EXC_BOTH;
    end else if (load || store) begin
      // Alignment wins over range when both are wrong.
      if (addr[1:0] != 2'b00) begin
        exc_code = EXC_MISALIGN;
      end else if ((addr < DATA_BASE) || ({1'b0, addr} >= UPPER)) begin
        exc_code = EXC_RANGE;
      end
    end
    legal = (exc_code == EXC_NONE);
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage requester for data_memory with MEM/WB writeback and exceptions
// Ports:
//   clk, reset                 rising-edge clock, async active-high reset
//   in_valid/in_ready          EX/MEM operation handshake
//   in_load, in_store          operation type (neither = ALU pass-through)
//   in_addr, in_wdata          address / ALU value and store data
//   in_rd, in_reg_write        destination register and its write enable
//   MemRead, MemWrite          registered data_memory strobes
//   ALUresult, WriteData       registered data_memory address and write data
//   data_result                data_memory read data, valid during the MemRead cycle
//   wb_valid, wb_data, wb_rd, wb_reg_write  MEM/WB bundle, wb_valid is a 1-cycle pulse
//   exc_valid, exc_code, exc_addr           illegal access report, exc_valid is a 1-cycle pulse
module mem_access_unit
  import mem_pkg::*;
#(
  parameter logic [31:0] DATA_BASE  = DATA_BASE_DEFAULT,
  parameter int          DATA_WORDS = DATA_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_load,
  input  logic        in_store,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [4:0]  in_rd,
  input  logic        in_reg_write,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] ALUresult,
  output logic [31:0] WriteData,
  input  logic [31:0] data_result,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic        exc_valid,
  output logic [1:0]  exc_code,
  output logic [31:0] exc_addr
);

  state_e      state_q, state_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wb_valid_q, wb_valid_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        wb_rw_q, wb_rw_d;
  logic        exc_valid_q, exc_valid_d;
  logic [1:0]  exc_code_q, exc_code_d;
  logic [31:0] exc_addr_q, exc_addr_d;
  // Destination of the load in flight, applied to wb_* when its data returns.
  logic [4:0]  ld_rd_q, ld_rd_d;
  logic        ld_rw_q, ld_rw_d;

  logic        legal;
  logic [1:0]  chk_code;

  mem_addr_check #(
    .DATA_BASE  (DATA_BASE),
    .DATA_WORDS (DATA_WORDS)
  ) u_check (
    .addr     (in_addr),
    .load     (in_load),
    .store    (in_store),
    .legal    (legal),
    .exc_code (chk_code)
  );

  // Held low while reset is asserted so nothing is offered before release.
  assign in_ready = !reset && (state_q == ST_IDLE);

  always_comb begin
    state_d     = state_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    alu_d       = '0;
    wdata_d     = '0;
    wb_valid_d  = 1'b0;
    wb_data_d   = wb_data_q;
    wb_rd_d     = wb_rd_q;
    wb_rw_d     = wb_rw_q;
    exc_valid_d = 1'b0;
    exc_code_d  = exc_code_q;
    exc_addr_d  = exc_addr_q;
    ld_rd_d     = ld_rd_q;
    ld_rw_d     = ld_rw_q;

    case (state_q)
      ST_LOAD: begin
        // MemRead is high this cycle, so data_result is the loaded word.
        state_d    = ST_IDLE;
        wb_valid_d = 1'b1;
        wb_data_d  = data_result;
        wb_rd_d    = ld_rd_q;
        wb_rw_d    = ld_rw_q;
      end
      default: begin
        if (in_valid) begin
          if (!legal) begin
            exc_valid_d = 1'b1;
            exc_code_d  = chk_code;
            exc_addr_d  = in_addr;
          end else if (in_store) begin
            mem_write_d = 1'b1;
            alu_d       = in_addr;
            wdata_d     = in_wdata;
          end else if (in_load) begin
            state_d    = ST_LOAD;
            mem_read_d = 1'b1;
            alu_d      = in_addr;
            ld_rd_d    = in_rd;
            ld_rw_d    = in_reg_write && (in_rd != 5'd0);
          end else begin
            wb_valid_d = 1'b1;
            wb_data_d  = in_addr;
            wb_rd_d    = in_rd;
            wb_rw_d    = in_reg_write && (in_rd != 5'd0);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      alu_q       <= '0;
      wdata_q     <= '0;
      wb_valid_q  <= 1'b0;
      wb_data_q   <= '0;
      wb_rd_q     <= '0;
      wb_rw_q     <= 1'b0;
      exc_valid_q <= 1'b0;
      exc_code_q  <= EXC_NONE;
      exc_addr_q  <= '0;
      ld_rd_q     <= '0;
      ld_rw_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      alu_q       <= alu_d;
      wdata_q     <= wdata_d;
      wb_valid_q  <= wb_valid_d;
      wb_data_q   <= wb_data_d;
      wb_rd_q     <= wb_rd_d;
      wb_rw_q     <= wb_rw_d;
      exc_valid_q <= exc_valid_d;
      exc_code_q  <= exc_code_d;
      exc_addr_q  <= exc_addr_d;
      ld_rd_q     <= ld_rd_d;
      ld_rw_q     <= ld_rw_d;
    end
  end

  assign MemRead      = mem_read_q;
  assign MemWrite     = mem_write_q;
  assign ALUresult    = alu_q;
  assign WriteData    = wdata_q;
  assign wb_valid     = wb_valid_q;
  assign wb_data      = wb_data_q;
  assign wb_rd        = wb_rd_q;
  assign wb_reg_write = wb_rw_q;
  assign exc_valid    = exc_valid_q;
  assign exc_code     = exc_code_q;
  assign exc_addr     = exc_addr_q;

endmodule
